// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-index width and load-tracking defaults.
package riscv_pkg;
    localparam int REGW = 5;
    localparam int MAX_OUT_DEF = 2;
    typedef logic [REGW-1:0] reg_idx_t;
endpackage

// File: rtl/load_hazard_unit_tag_fifo.sv
// tag_fifo: in-order FIFO of load destination tags with per-entry visibility for hazard compares.
module tag_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push,
    input  logic [W-1:0]              wdata,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [W-1:0]              head,
    output logic [DEPTH-1:0]          valid,
    output logic [DEPTH-1:0][W-1:0]   rd
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] rptr, wptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign head    = rd[rptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
            valid <= '0;
            rd    <= '0;
        end else begin
            if (do_pop) begin
                valid[rptr] <= 1'b0;
                rptr        <= nxt(rptr);
            end
            if (do_push) begin
                valid[wptr] <= 1'b1;
                rd[wptr]    <= wdata;
                wptr        <= nxt(wptr);
            end
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/load_hazard_unit.sv
// load_hazard_unit: stalls execute on RAW/WAW/structural hazards against outstanding loads
// and writes back returned load data in order.
module load_hazard_unit
    import riscv_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int CNTW    = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [REGW-1:0] rs1_e,
    input  logic [REGW-1:0] rs2_e,
    input  logic            rs1_used_e,
    input  logic            rs2_used_e,
    input  logic [REGW-1:0] rd_e,
    input  logic            reg_write_e,
    input  logic            load_e,
    input  logic            branch_taken_e,
    input  logic            lsu_req_ready_i,
    input  logic            lsu_rsp_valid_i,
    output logic            lsu_req_valid_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            wb_valid_o,
    output logic [REGW-1:0] wb_rd_o,
    output logic            err_o,
    output logic [CNTW-1:0] stall_cnt_o
);
    logic                          full, empty;
    logic [MAX_OUT-1:0]            ent_valid;
    logic [MAX_OUT-1:0][REGW-1:0]  ent_rd;
    logic [MAX_OUT-1:0]            hit1, hit2, hitd;
    logic                          raw, waw, structural;

    tag_fifo #(.DEPTH(MAX_OUT), .W(REGW)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (lsu_req_valid_o),
        .wdata (rd_e),
        .pop   (lsu_rsp_valid_i),
        .full  (full),
        .empty (empty),
        .head  (wb_rd_o),
        .valid (ent_valid),
        .rd    (ent_rd)
    );

    for (genvar i = 0; i < MAX_OUT; i++) begin : g_cmp
        assign hit1[i] = ent_valid[i] && ent_rd[i] == rs1_e;
        assign hit2[i] = ent_valid[i] && ent_rd[i] == rs2_e;
        assign hitd[i] = ent_valid[i] && ent_rd[i] == rd_e;
    end

    // x0 is never a real dependency, so it is masked out of every compare.
    assign raw        = (rs1_used_e && |rs1_e && |hit1) || (rs2_used_e && |rs2_e && |hit2);
    assign waw        = reg_write_e && |rd_e && |hitd;
    assign structural = load_e && ((full && !wb_valid_o) || !lsu_req_ready_i);

    assign wb_valid_o      = lsu_rsp_valid_i && !empty;
    assign stall_o         = raw || waw || structural;
    assign lsu_req_valid_o = load_e && !stall_o;
    assign flush_o         = branch_taken_e && !stall_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_o       <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (lsu_rsp_valid_i && empty)
                err_o <= 1'b1;
            if (stall_o && !(&stall_cnt_o))
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_load_hazard_unit.sv
// tb_load_hazard_unit: directed and random stimulus checked against a queue-based reference model.
module tb_load_hazard_unit;
    import riscv_pkg::*;

    localparam int MAXO = 2;
    localparam int CW   = 16;
    localparam int SAT  = (1 << CW) - 1;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [REGW-1:0] rs1_e, rs2_e, rd_e;
    logic            rs1_used_e, rs2_used_e, reg_write_e, load_e, branch_taken_e;
    logic            lsu_req_ready_i, lsu_rsp_valid_i;
    logic            lsu_req_valid_o, stall_o, flush_o, wb_valid_o, err_o;
    logic [REGW-1:0] wb_rd_o;
    logic [CW-1:0]   stall_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    int q[$];
    bit m_err;
    int m_cnt;

    load_hazard_unit #(.MAX_OUT(MAXO), .CNTW(CW)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .rs1_e           (rs1_e),
        .rs2_e           (rs2_e),
        .rs1_used_e      (rs1_used_e),
        .rs2_used_e      (rs2_used_e),
        .rd_e            (rd_e),
        .reg_write_e     (reg_write_e),
        .load_e          (load_e),
        .branch_taken_e  (branch_taken_e),
        .lsu_req_ready_i (lsu_req_ready_i),
        .lsu_rsp_valid_i (lsu_rsp_valid_i),
        .lsu_req_valid_o (lsu_req_valid_o),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .wb_valid_o      (wb_valid_o),
        .wb_rd_o         (wb_rd_o),
        .err_o           (err_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pend(input int r);
        if (r == 0) return 1'b0;
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        rs1_e = '0; rs2_e = '0; rd_e = '0;
        rs1_used_e = 0; rs2_used_e = 0; reg_write_e = 0; load_e = 0;
        branch_taken_e = 0; lsu_req_ready_i = 1; lsu_rsp_valid_i = 0;
    endtask

    task automatic set_op(input bit ld, input bit wr, input int rd, input bit u1, input int r1,
                          input bit u2, input int r2);
        load_e = ld; reg_write_e = wr; rd_e = REGW'(rd);
        rs1_used_e = u1; rs1_e = REGW'(r1); rs2_used_e = u2; rs2_e = REGW'(r2);
    endtask

    // Called just after a negedge with inputs applied; checks, clocks, advances the model.
    task automatic cycle();
        bit pop, stall, issue;
        int sz;
        #1;
        sz    = q.size();
        pop   = lsu_rsp_valid_i && sz > 0;
        stall = (rs1_used_e && pend(int'(rs1_e))) || (rs2_used_e && pend(int'(rs2_e)))
             || (reg_write_e && pend(int'(rd_e)))
             || (load_e && ((sz == MAXO && !pop) || !lsu_req_ready_i));
        issue = load_e && !stall;
        check("stall", stall_o, stall);
        check("req_valid", lsu_req_valid_o, issue);
        check("flush", flush_o, branch_taken_e && !stall);
        check("wb_valid", wb_valid_o, pop);
        if (pop) check("wb_rd", wb_rd_o, q[0]);
        check("err", err_o, m_err);
        check("stall_cnt", stall_cnt_o, m_cnt);
        @(posedge clk_i);
        if (lsu_rsp_valid_i && sz == 0) m_err = 1'b1;
        if (pop) void'(q.pop_front());
        if (issue) q.push_back(int'(rd_e));
        if (stall && m_cnt < SAT) m_cnt++;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b0;
        q.delete(); m_err = 0; m_cnt = 0;
        #1;
        check("rst_err", err_o, 0);
        check("rst_cnt", stall_cnt_o, 0);
        check("rst_stall", stall_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1;
        q.delete(); m_err = 0; m_cnt = 0;
        @(negedge clk_i);
        do_reset();

        // load x5, dependent reader stalls until the response
        set_op(1, 1, 5, 0, 0, 0, 0); cycle();
        set_op(0, 1, 9, 1, 5, 0, 0); cycle(); cycle();
        check("raw_stall", stall_o, 1);
        lsu_rsp_valid_i = 1; #1;
        check("x5_wb_rd", wb_rd_o, 5);
        cycle();
        lsu_rsp_valid_i = 0; cycle();

        // two loads outstanding, third presented with and without a response
        set_op(1, 1, 3, 0, 0, 0, 0); cycle();
        set_op(1, 1, 4, 0, 0, 0, 0); cycle();
        set_op(1, 1, 6, 0, 0, 0, 0); cycle();
        lsu_rsp_valid_i = 1; cycle();
        set_op(0, 0, 0, 0, 0, 0, 0); #1;
        check("head_x4", wb_rd_o, 4);
        cycle(); cycle();
        lsu_rsp_valid_i = 0;

        // WAW on x7, and x0 reads never stall
        set_op(1, 1, 7, 0, 0, 0, 0); cycle();
        set_op(0, 1, 7, 1, 0, 1, 0); cycle(); cycle();
        lsu_rsp_valid_i = 1; cycle();
        lsu_rsp_valid_i = 0; cycle();

        // branch during a RAW stall is dropped, after the stall it flushes
        set_op(1, 1, 2, 0, 0, 0, 0); cycle();
        set_op(0, 0, 0, 1, 2, 0, 0); branch_taken_e = 1; cycle();
        lsu_rsp_valid_i = 1; cycle();
        lsu_rsp_valid_i = 0; cycle();
        branch_taken_e = 0;

        // response with nothing outstanding, then reset mid-load
        idle(); lsu_rsp_valid_i = 1; cycle();
        lsu_rsp_valid_i = 0; cycle(); cycle();
        set_op(1, 1, 8, 0, 0, 0, 0); cycle();
        do_reset();
        lsu_rsp_valid_i = 1; cycle();
        lsu_rsp_valid_i = 0; cycle();

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            set_op($urandom_range(0, 9) < 4, $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 7));
            branch_taken_e  = $urandom_range(0, 4) == 0;
            lsu_req_ready_i = $urandom_range(0, 9) != 0;
            lsu_rsp_valid_i = $urandom_range(0, 9) < 3;
            cycle();
        end

        // hold a structural stall long enough to saturate the counter
        idle(); load_e = 1; lsu_req_ready_i = 0;
        for (int n = 0; n < SAT + 4; n++) cycle();
        check("cnt_sat", stall_cnt_o, SAT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/load_hazard_unit.md
LOAD_HAZARD_UNIT -- requirements
Module: load_hazard_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- MAX_OUT, 2, maximum outstanding loads (FIFO depth).
- CNTW, 16, width of the stall-cycle performance counter.

REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.

REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- rs1_e  in  REGW  rs1 of the instruction in execute.
- rs2_e  in  REGW  rs2 of the instruction in execute.
- rs1_used_e  in  1  instruction reads rs1.
- rs2_used_e  in  1  instruction reads rs2.
- rd_e  in  REGW  destination of the instruction in execute.
- reg_write_e  in  1  instruction writes rd_e.
- load_e  in  1  instruction is a load.
- branch_taken_e  in  1  redirect resolved in execute.
- lsu_req_ready_i  in  1  data memory accepts a request.
- lsu_rsp_valid_i  in  1  load data returned (in order).
- lsu_req_valid_o  out  1  load request issued.
- stall_o  out  1  hold PC and the F/E register.
- flush_o  out  1  bubble the F/E register.
- wb_valid_o  out  1  write load data to the register file.
- wb_rd_o  out  REGW  destination for the returned load.
- err_o  out  1  sticky protocol error.
- stall_cnt_o  out  CNTW  stall-cycle count.

Function
REQ-004 The block SHALL keep an in-order tag FIFO of MAX_OUT entries, each entry holding a valid bit and an rd, plus an occupancy count in 0..MAX_OUT.
REQ-005 A pending hit SHALL be declared for register r when r != 0 and any valid entry's rd == r.
REQ-006 A raw hazard SHALL assert when (rs1_used_e and rs1 pending) or (rs2_used_e and rs2 pending).
REQ-007 A waw hazard SHALL assert when reg_write_e and rd_e is pending.
REQ-008 A structural hazard SHALL assert when load_e and (count == MAX_OUT with no response this cycle, or lsu_req_ready_i == 0).
REQ-009 stall_o SHALL equal raw or waw or structural, combinationally from the registered FIFO state and current inputs.
REQ-010 lsu_req_valid_o SHALL equal load_e and not stall_o; a handshake completes in that cycle, and the block SHALL push rd_e at the next clock edge.
REQ-011 When lsu_rsp_valid_i and count > 0, wb_valid_o SHALL be 1 and wb_rd_o SHALL be the head rd in the same cycle; the head SHALL pop at the clock edge.
REQ-012 A push and a pop in the same cycle SHALL leave count unchanged, and this SHALL be permitted when full.
REQ-013 Hazards SHALL be evaluated on FIFO state at cycle start; a pop SHALL clear the hit from the following cycle, with no same-cycle bypass.
REQ-014 When lsu_rsp_valid_i and count == 0, the block SHALL ignore the response, hold wb_valid_o at 0, and set err_o until reset.
REQ-015 flush_o SHALL equal branch_taken_e and not stall_o; a taken branch seen while stalled SHALL be ignored, since it is re-presented on the next cycle.
REQ-016 The FIFO read and write pointers SHALL wrap modulo MAX_OUT.
REQ-017 stall_cnt_o SHALL increment on every cycle with stall_o == 1 and saturate at all-ones.

Reset
REQ-018 While rst_i == 0, the block SHALL force count = 0, all entries invalid, pointers = 0, err_o = 0 and stall_cnt_o = 0.
REQ-019 Reset mid-operation SHALL discard outstanding tags; a response arriving after reset SHALL set err_o.
REQ-020 With an empty FIFO, stall_o, lsu_req_valid_o and wb_valid_o SHALL depend only on the current inputs.

Structure
REQ-021 REGW and a MAX_OUT default constant SHALL reside in riscv_pkg.
REQ-022 The tag FIFO SHALL be a sub-module named tag_fifo, parameterised by depth and width, with push, pop, full, empty and head outputs, plus per-entry valid and rd for comparison.

Verification
REQ-023 Load x5 issued, next instruction reads rs1 = x5 with no response -> stall_o = 1 each cycle; response -> wb_rd_o = 5, wb_valid_o = 1; stall_o = 0 on the following cycle.
REQ-024 Two loads (x3, x4) outstanding, third load presented -> stall_o = 1 and lsu_req_valid_o = 0; response in the same cycle -> the third issues, count stays 2, head becomes x4.
REQ-025 ALU write to x7 while a load to x7 is pending -> waw stall until the response; a read of rs1 = x0 with x0 never pending -> no stall.
REQ-026 branch_taken_e = 1 during a raw stall -> flush_o = 0; branch_taken_e = 1 after the stall clears -> flush_o = 1.
REQ-027 lsu_rsp_valid_i pulsed with the FIFO empty -> err_o = 1 and held; rst_i pulsed low mid-load -> count = 0, stall_cnt_o = 0.
REQ-028 Hold a stall for 2^CNTW + 3 cycles -> stall_cnt_o saturates at all-ones.
